// File: rtl/wash_prep_controller_if.sv
// Handshake/sensor bundle between the wash control unit and the preparation stage.
interface wash_prep_controller_if #(parameter int W = 8);
  logic         prep_req;
  logic         abort;
  logic         cycle_done;
  logic [W-1:0] target_level;
  logic [W-1:0] target_temp;
  logic [W-1:0] water_level;
  logic [W-1:0] temp_sensor;
  logic [W-1:0] load_weight;
  logic         fill_valve;
  logic         heater_on;
  logic         load_ready;
  logic         water_ready;
  logic         temp_ready;
  logic         busy;
  logic         fault;
  logic [1:0]   fault_code;

  modport master (
    output prep_req, abort, cycle_done, target_level, target_temp,
           water_level, temp_sensor, load_weight,
    input  fill_valve, heater_on, load_ready, water_ready, temp_ready,
           busy, fault, fault_code
  );

  modport slave (
    input  prep_req, abort, cycle_done, target_level, target_temp,
           water_level, temp_sensor, load_weight,
    output fill_valve, heater_on, load_ready, water_ready, temp_ready,
           busy, fault, fault_code
  );
endinterface

// File: rtl/wash_prep_controller.sv
// Wash preparation: load check, fill, heat, then hold readies until cycle_done.
// Per-phase timeouts latch a fault; every output is a flop.
module wash_prep_controller #(
  parameter int W            = 8,
  parameter int DEBOUNCE     = 4,
  parameter int LOAD_TIMEOUT = 64,
  parameter int FILL_TIMEOUT = 1000,
  parameter int HEAT_TIMEOUT = 2000,
  parameter int HYST         = 2,
  parameter int LOAD_MIN     = 10,
  parameter int LOAD_MAX     = 200
) (
  input  logic                  clk,
  input  logic                  reset,
  wash_prep_controller_if.slave bus
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE);
  localparam logic [15:0]   LOAD_END = 16'(LOAD_TIMEOUT - 1);
  localparam logic [15:0]   FILL_END = 16'(FILL_TIMEOUT - 1);
  localparam logic [15:0]   HEAT_END = 16'(HEAT_TIMEOUT - 1);
  localparam logic [W-1:0]  HYST_W   = W'(HYST);
  localparam logic [W-1:0]  LMIN_W   = W'(LOAD_MIN);
  localparam logic [W-1:0]  LMAX_W   = W'(LOAD_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_CHK, S_FILL, S_HEAT, S_READY, S_FAULT
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [W-1:0]  tlev_q, tlev_d, ttemp_q, ttemp_d;
  logic          fill_q, fill_d, heat_q, heat_d;
  logic          lrdy_q, lrdy_d, wrdy_q, wrdy_d, trdy_q, trdy_d;
  logic          busy_q, busy_d, fault_q, fault_d;
  logic [1:0]    code_q, code_d;

  logic [W-1:0]  thr;
  logic          load_ok;

  // Lower hysteresis threshold, saturating at zero for small targets.
  assign thr     = (ttemp_q >= HYST_W) ? (ttemp_q - HYST_W) : '0;
  assign load_ok = (bus.load_weight >= LMIN_W) && (bus.load_weight <= LMAX_W);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    deb_d   = deb_q;
    tlev_d  = tlev_q;
    ttemp_d = ttemp_q;
    fill_d  = fill_q;
    heat_d  = heat_q;
    lrdy_d  = lrdy_q;
    wrdy_d  = wrdy_q;
    trdy_d  = trdy_q;
    busy_d  = busy_q;
    fault_d = fault_q;
    code_d  = code_q;

    if (bus.abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      deb_d   = '0;
      fill_d  = 1'b0;
      heat_d  = 1'b0;
      lrdy_d  = 1'b0;
      wrdy_d  = 1'b0;
      trdy_d  = 1'b0;
      busy_d  = 1'b0;
      fault_d = 1'b0;
      code_d  = 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (bus.prep_req) begin
            tlev_d  = bus.target_level;
            ttemp_d = bus.target_temp;
            deb_d   = '0;
            busy_d  = 1'b1;
            state_d = S_LOAD_CHK;
          end
        end
        S_LOAD_CHK: begin
          if (deb_q == DEB_MAX) begin
            lrdy_d  = 1'b1;
            fill_d  = 1'b1;
            cnt_d   = '0;
            state_d = S_FILL;
          end else if (cnt_q == LOAD_END) begin
            busy_d  = 1'b0;
            fault_d = 1'b1;
            code_d  = 2'b01;
            cnt_d   = '0;
            state_d = S_FAULT;
          end else begin
            deb_d = load_ok ? (deb_q + DW'(1)) : '0;
          end
        end
        S_FILL: begin
          if (bus.water_level >= tlev_q) begin
            fill_d  = 1'b0;
            wrdy_d  = 1'b1;
            heat_d  = 1'b1;
            cnt_d   = '0;
            state_d = S_HEAT;
          end else if (cnt_q == FILL_END) begin
            fill_d  = 1'b0;
            lrdy_d  = 1'b0;
            busy_d  = 1'b0;
            fault_d = 1'b1;
            code_d  = 2'b10;
            cnt_d   = '0;
            state_d = S_FAULT;
          end
        end
        S_HEAT: begin
          if (bus.temp_sensor >= ttemp_q) begin
            heat_d  = 1'b0;
            trdy_d  = 1'b1;
            cnt_d   = '0;
            state_d = S_READY;
          end else if (cnt_q == HEAT_END) begin
            heat_d  = 1'b0;
            lrdy_d  = 1'b0;
            wrdy_d  = 1'b0;
            busy_d  = 1'b0;
            fault_d = 1'b1;
            code_d  = 2'b11;
            cnt_d   = '0;
            state_d = S_FAULT;
          end
        end
        S_READY: begin
          if (bus.cycle_done) begin
            heat_d  = 1'b0;
            lrdy_d  = 1'b0;
            wrdy_d  = 1'b0;
            trdy_d  = 1'b0;
            busy_d  = 1'b0;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            // Between thr and target the heater keeps its previous state.
            trdy_d = (bus.temp_sensor >= thr);
            if (bus.temp_sensor < thr)
              heat_d = 1'b1;
            else if (bus.temp_sensor >= ttemp_q)
              heat_d = 1'b0;
          end
        end
        S_FAULT: ;
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      deb_q   <= '0;
      tlev_q  <= '0;
      ttemp_q <= '0;
      fill_q  <= 1'b0;
      heat_q  <= 1'b0;
      lrdy_q  <= 1'b0;
      wrdy_q  <= 1'b0;
      trdy_q  <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
      tlev_q  <= tlev_d;
      ttemp_q <= ttemp_d;
      fill_q  <= fill_d;
      heat_q  <= heat_d;
      lrdy_q  <= lrdy_d;
      wrdy_q  <= wrdy_d;
      trdy_q  <= trdy_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
      code_q  <= code_d;
    end
  end

  assign bus.fill_valve  = fill_q;
  assign bus.heater_on   = heat_q;
  assign bus.load_ready  = lrdy_q;
  assign bus.water_ready = wrdy_q;
  assign bus.temp_ready  = trdy_q;
  assign bus.busy        = busy_q;
  assign bus.fault       = fault_q;
  assign bus.fault_code  = code_q;

endmodule

// File: doc/wash_prep_controller.md
Name: wash_prep_controller

Overview:
Upstream preparation stage for the wash sequencer. On a preparation request it checks the drum load, fills water to a target level and heats it to a target temperature. It then holds water_ready, temp_ready and load_ready high for the control unit until that unit reports cycle completion. Per-phase timeouts raise a latched fault instead of leaving the sequencer waiting forever.

Parameters:
W, 8, width of level, temperature and weight buses
DEBOUNCE, 4, consecutive in-range cycles required to accept the load
LOAD_TIMEOUT, 64, max cycles in LOAD_CHK
FILL_TIMEOUT, 1000, max cycles in FILL
HEAT_TIMEOUT, 2000, max cycles in HEAT
HYST, 2, temperature hysteresis in sensor LSBs
LOAD_MIN, 10, min acceptable load_weight (inclusive)
LOAD_MAX, 200, max acceptable load_weight (inclusive)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
prep_req  in  1  start preparation; sampled only in IDLE
abort  in  1  return to IDLE from any state; clears fault
cycle_done  in  1  completion pulse from control unit (its complete output)
target_level  in  W  fill target; latched on accepted prep_req
target_temp  in  W  heat target; latched on accepted prep_req
water_level  in  W  level sensor
temp_sensor  in  W  temperature sensor
load_weight  in  W  load sensor
fill_valve  out  1  water inlet valve open
heater_on  out  1  heater element on
load_ready  out  1  to control unit
water_ready  out  1  to control unit
temp_ready  out  1  to control unit
busy  out  1  high in any state other than IDLE and FAULT
fault  out  1  latched fault
fault_code  out  2  00 none, 01 load, 10 fill, 11 heat

Behaviour:
- All outputs are flops. Reset value of every output is 0. Reset state is IDLE, the phase counter is 0 and the latched targets are 0.
- Priority each cycle: reset > abort > state transitions.
- abort: next state IDLE. All outputs are 0 on the following cycle. fault and fault_code are cleared.
- States: IDLE, LOAD_CHK, FILL, HEAT, READY, FAULT. The phase counter is 16 bits, clears on every state change and increments each cycle inside a phase.
- IDLE: if prep_req=1, latch target_level and target_temp, then go to LOAD_CHK. prep_req in any other state is ignored.
- LOAD_CHK: the debounce counter increments when LOAD_MIN <= load_weight <= LOAD_MAX and clears otherwise.
  - When it reaches DEBOUNCE, set load_ready=1 and go to FILL.
  - Otherwise, if the phase counter reaches LOAD_TIMEOUT, go to FAULT with code 01.
- FILL: fill_valve=1 while in state.
  - If water_level >= latched target_level, close the valve, set water_ready=1 and go to HEAT.
  - Level already at target on entry: leave after one cycle in FILL.
  - Timeout FILL_TIMEOUT: go to FAULT with code 10 and close the valve.
- HEAT: heater_on=1.
  - If temp_sensor >= latched target_temp, set temp_ready=1 and go to READY.
  - Timeout HEAT_TIMEOUT: go to FAULT with code 11 and turn heater_on off.
- READY: load_ready and water_ready held at 1. Heater maintenance with hysteresis:
  - heater_on goes to 1 when temp_sensor < target_temp - HYST and to 0 when temp_sensor >= target_temp.
  - temp_ready = (temp_sensor >= target_temp - HYST).
  - target_temp - HYST saturates at 0.
  - cycle_done=1: go to IDLE and clear all outputs next cycle.
- FAULT: fault=1 and fault_code holds its value. fill_valve, heater_on and all ready outputs are 0. Only abort or reset leave FAULT; prep_req is ignored here.
- Transitions and output updates take effect on the clock edge after the qualifying input is sampled. Latency from prep_req to load_ready is DEBOUNCE+1 cycles minimum.
- cycle_done outside READY is ignored.
- Sensor comparisons are unsigned W-bit. The debounce counter saturates at DEBOUNCE.

Test Plan:
- Nominal run, with target_level=50, target_temp=40 and load_weight=100 constant. prep_req pulse -> load_ready=1 after 5 cycles. water_level ramps 0->50 -> fill_valve high until level hits 50, then water_ready=1. temp ramps to 40 -> temp_ready=1 and state READY. cycle_done -> all outputs 0 next cycle.
- Load bounce: load_weight alternates 100/5 for 10 cycles, then stays 100 -> load_ready=1 exactly 4 cycles after the last in-range transition. load_weight held at 250 -> fault=1 and fault_code=01 at cycle 64.
- Fill timeout: water_level stuck at 10 -> fill_valve=0, fault=1 and fault_code=10 after 1000 FILL cycles. prep_req is then ignored; abort clears fault.
- Hysteresis in READY with target 40 and HYST 2: temp 39 -> heater_on stays 0 and temp_ready=1. Temp 37 -> heater_on=1 and temp_ready=0. Temp 40 -> heater_on=0 and temp_ready=1.
- Abort and reset mid-operation: abort during HEAT -> IDLE, with heater_on and readies 0 next cycle. Synchronous reset asserted in FILL -> all outputs 0 at the next edge, not before.
- Immediate targets: water_level=60 at FILL entry with target 50 -> exactly one cycle of fill_valve=1, then water_ready=1.
